ex_lsu: RTL and testbench
=========================

// Module: ex_lsu
// PURPOSE
//  EX-stage load/store unit. Computes the effective address, runs the data-memory req/gnt/rvalid handshake,
//  and stalls the pipeline while an access is outstanding. Aligns and sign- or zero-extends load data.
//  Feeds result_ld_i/ctrl_ld_i of the downstream EX pipeline register; stall_o holds the upstream stages.
// PARAMETERS
//  TIMEOUT   default 16   max cycles in WAIT before a bus error is declared (>=2)
//  CNT_W     default 5    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous reset, active-low
//  ctrl_ld_i     in   1   load instruction in EX; held stable while stall_o=1
//  ctrl_st_i     in   1   store instruction in EX; held stable while stall_o=1
//  funct3_i      in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//  base_i        in   32  rs1 value
//  offset_i      in   32  sign-extended immediate
//  wdata_i       in   32  rs2 value (store data, low bytes)
//  mem_req_o     out  1   memory request, registered
//  mem_we_o      out  1   1 = write
//  mem_addr_o    out  32  word-aligned address {ea[31:2],2'b00}
//  mem_wdata_o   out  32  store data replicated to byte lanes
//  mem_wstrb_o   out  4   byte enables (loads: 4'b0000)
//  mem_gnt_i     in   1   request accepted
//  mem_rvalid_i  in   1   read data valid
//  mem_rdata_i   in   32  read data
//  result_ld_o   out  32  extended load result
//  ld_valid_o    out  1   load/store completed this cycle
//  stall_o       out  1   hold pipeline
//  exc_o         out  1   one-cycle exception pulse
//  exc_cause_o   out  2   01 misaligned, 10 illegal funct3, 11 bus timeout
// BEHAVIOUR
//  - ea = base_i + offset_i, modulo 2**32; off = ea[1:0].
//  - Reset (rst=0 at posedge): state IDLE; all outputs 0; counter 0; result_ld_o 0.
//    Applies mid-access. An rvalid arriving after reset, while in IDLE, is ignored.
//  - FSM states: IDLE, REQ, WAIT, DONE.
//    * IDLE: if ctrl_ld_i|ctrl_st_i:
//      - illegal funct3 (load 011/11x; store other than 000/001/010) -> exc_o=1, cause 10, stay IDLE.
//      - misaligned (H with off[0]=1, W with off!=0) -> exc_o=1, cause 01, stay IDLE.
//      - in both error cases: no request, stall_o=0.
//      - otherwise stall_o=1 (combinational), register addr/we/wdata/wstrb, go REQ.
//      - ld and st both set: treat as load.
//    * REQ: mem_req_o=1, stall_o=1, outputs stable until mem_gnt_i.
//      On gnt: store -> DONE; load -> WAIT, counter cleared.
//    * WAIT: mem_req_o=0, stall_o=1, counter++ per cycle.
//      rvalid -> capture extended data to result_ld_o, go DONE.
//      counter==TIMEOUT without rvalid -> exc_o=1, cause 11, result_ld_o=0, go DONE.
//      rvalid in the same cycle as gnt is not allowed; it is ignored in REQ.
//    * DONE: ld_valid_o=1 (0 if timed out), stall_o=0, go IDLE.
//      ctrl_* seen in DONE belong to the finishing instruction and are ignored.
//  - Store lanes:
//    * SB: wdata = {4{wdata_i[7:0]}}, wstrb = 1<<off.
//    * SH: wdata = {2{wdata_i[15:0]}}, wstrb = 4'b0011<<off.
//    * SW: wstrb = 4'b1111.
//  - Load extract: byte = rdata[8*off+:8], half = rdata[8*off+:16]; B/H sign-extend, BU/HU zero-extend.
//  - result_ld_o holds its value until the next load completes.
//  - Min latency, load with gnt in the first REQ cycle and rvalid next: request at T, result valid at T+3.
//  - Min latency, store: request at T, done at T+2.
// TESTING
//  1 LW base=0x1000 off=4, gnt @T+1, rdata=0xDEADBEEF @T+2
//    -> mem_addr_o=0x1004, result_ld_o=0xDEADBEEF, ld_valid_o @T+3, stall_o high T..T+2.
//  2 LB ea=0x2003, rdata=0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU ea=0x2002 -> 0x00008011.
//  3 SH ea=0x3002, wdata_i=0x0000ABCD -> mem_wdata_o=0xABCDABCD, wstrb=4'b1100, we=1, done @T+2.
//  4 LW ea=0x4001 -> exc_o pulse, cause 01, no mem_req_o, stall_o=0. funct3=011 load -> cause 10.
//  5 gnt delayed 3 cycles, then no rvalid for TIMEOUT cycles
//    -> req held stable, exc cause 11, result 0, ld_valid_o=0, return to IDLE.
//  6 rst=0 during WAIT, then rvalid -> outputs 0, state IDLE, late rvalid ignored; next LW works normally.

Source files
------------

// File: rtl/ex_lsu_if.sv
// ex_lsu_if: data-memory req/gnt/rvalid bus between the load/store unit and memory
interface ex_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/ex_lsu.sv
// ex_lsu: EX-stage load/store unit with memory handshake, stall, timeout and load extension
module ex_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_ld_i,
  input  logic            ctrl_st_i,
  input  logic [2:0]      funct3_i,
  input  logic [31:0]     base_i,
  input  logic [31:0]     offset_i,
  input  logic [31:0]     wdata_i,
  ex_lsu_if.master        mem,
  output logic [31:0]     result_ld_o,
  output logic            ld_valid_o,
  output logic            stall_o,
  output logic            exc_o,
  output logic [1:0]      exc_cause_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [31:0] ea;
  logic [1:0] off;
  logic act, ld, bad_f3, mis, go;
  logic [31:0] st_wdata;
  logic [3:0] st_wstrb;
  logic [15:0] sh;
  logic [31:0] ld_ext;
  always_comb begin
    ea = base_i + offset_i;
    off = ea[1:0];
    act = ctrl_ld_i | ctrl_st_i;
    ld = ctrl_ld_i;
    bad_f3 = ld ? (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) : (funct3_i[2] || funct3_i[1:0] == 2'b11);
    mis = (funct3_i[1:0] == 2'b01 && off[0]) || (funct3_i[1:0] == 2'b10 && off != 2'b00);
    go = state == IDLE && act && !bad_f3 && !mis;
    stall_o = go || state == REQ || state == WAIT;
    st_wdata = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} : funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    st_wstrb = funct3_i[1:0] == 2'b00 ? 4'b0001 << off : funct3_i[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    sh = 16'(mem.rdata >> {off_q, 3'b000});
    ld_ext = f3_q[1] ? mem.rdata :
             f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh} : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      off_q <= '0;
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.addr <= '0;
      mem.wdata <= '0;
      mem.wstrb <= '0;
      result_ld_o <= '0;
      ld_valid_o <= 1'b0;
      exc_o <= 1'b0;
      exc_cause_o <= 2'b00;
    end else begin
      ld_valid_o <= 1'b0;
      exc_o <= 1'b0;
      exc_cause_o <= 2'b00;
      case (state)
        IDLE: if (act) begin
          if (bad_f3 || mis) begin
            exc_o <= 1'b1;
            exc_cause_o <= bad_f3 ? 2'b10 : 2'b01;
          end else begin
            state <= REQ;
            mem.req <= 1'b1;
            mem.we <= !ld;
            mem.addr <= {ea[31:2], 2'b00};
            mem.wdata <= ld ? '0 : st_wdata;
            mem.wstrb <= ld ? 4'b0000 : st_wstrb;
            f3_q <= funct3_i;
            off_q <= off;
          end
        end
        REQ: if (mem.gnt) begin
          mem.req <= 1'b0;
          state <= mem.we ? DONE : WAIT;
          ld_valid_o <= mem.we;
          cnt <= '0;
        end
        WAIT: if (mem.rvalid) begin
          result_ld_o <= ld_ext;
          ld_valid_o <= 1'b1;
          state <= DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          exc_o <= 1'b1;
          exc_cause_o <= 2'b11;
          result_ld_o <= '0;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: directed and randomized load/store traffic checked against a behavioural LSU model
module tb_ex_lsu;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ctrl_ld = 1'b0, ctrl_st = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] base = '0, ofs = '0, wdata = '0;
  logic [31:0] result;
  logic ld_valid, stall, exc;
  logic [1:0] cause;
  logic [31:0] last_res = '0;
  int total = 0, bad = 0;
  ex_lsu_if mem();
  ex_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ctrl_ld_i(ctrl_ld), .ctrl_st_i(ctrl_st), .funct3_i(funct3),
    .base_i(base), .offset_i(ofs), .wdata_i(wdata), .mem(mem), .result_ld_o(result),
    .ld_valid_o(ld_valid), .stall_o(stall), .exc_o(exc), .exc_cause_o(cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic int exp_exc(input bit ld, input logic [2:0] f3, input logic [31:0] ea);
    bit legal;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 2;
    if (ea % size_of(f3) != 0) return 1;
    return 0;
  endfunction
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] rd, input logic [1:0] off);
    int nb;
    logic [31:0] v, mask;
    nb = size_of(f3);
    mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    v = (rd >> (8 * off)) & mask;
    if (f3 < 4 && nb < 4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] wd, input logic [31:0] rdata,
                        input int gd, input int rd);
    logic [31:0] ea, exp_wd, exp_res;
    logic [3:0] exp_strb;
    int ec, nb, nw;
    bit timed;
    ea = b + o;
    ec = exp_exc(ld, f3, ea);
    nb = size_of(f3);
    @(negedge clk);
    ctrl_ld = ld; ctrl_st = st; funct3 = f3; base = b; ofs = o; wdata = wd;
    #1 chk("stall_idle", stall, ec == 0);
    if (ec != 0) begin
      @(negedge clk);
      chk("exc_err", exc, 1);
      chk("cause_err", cause, ec);
      chk("req_err", mem.req, 0);
      chk("res_hold_err", result, last_res);
      ctrl_ld = 0; ctrl_st = 0;
      @(negedge clk);
      chk("exc_pulse", exc, 0);
      return;
    end
    exp_wd = nb == 1 ? wd[7:0] * 32'h0101_0101 : nb == 2 ? wd[15:0] * 32'h0001_0001 : wd;
    exp_strb = 4'(((1 << nb) - 1) << ea[1:0]);
    for (int c = 0; c <= gd; c++) begin
      @(negedge clk);
      chk("req", mem.req, 1);
      chk("we", mem.we, !ld);
      chk("addr", mem.addr, ea & 32'hFFFF_FFFC);
      chk("wstrb", mem.wstrb, ld ? 4'b0000 : exp_strb);
      if (!ld) chk("wdata", mem.wdata, exp_wd);
      chk("stall_req", stall, 1);
      mem.gnt = (c == gd);
      mem.rvalid = 1'($urandom_range(0, 1));
      mem.rdata = $urandom;
    end
    @(negedge clk);
    mem.gnt = 0; mem.rvalid = 0;
    timed = ld && !(rd >= 0 && rd <= TIMEOUT);
    if (ld) begin
      nw = timed ? TIMEOUT + 1 : rd + 1;
      for (int w = 0; w < nw; w++) begin
        if (w > 0) @(negedge clk);
        chk("req_wait", mem.req, 0);
        chk("stall_wait", stall, 1);
        chk("valid_wait", ld_valid, 0);
        mem.rvalid = (w == rd);
        mem.rdata = (w == rd) ? rdata : $urandom;
      end
      @(negedge clk);
      mem.rvalid = 0;
    end
    exp_res = timed ? 32'd0 : ld ? load_val(f3, rdata, ea[1:0]) : last_res;
    chk("ld_valid", ld_valid, !timed);
    chk("exc_done", exc, timed);
    chk("cause_done", cause, timed ? 2'b11 : 2'b00);
    chk("result", result, exp_res);
    chk("stall_done", stall, 0);
    chk("req_done", mem.req, 0);
    last_res = exp_res;
    ctrl_ld = 0; ctrl_st = 0;
  endtask
  initial begin
    mem.gnt = 0; mem.rvalid = 0; mem.rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", mem.req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", ld_valid, 0);
    chk("rst_exc", exc, 0);
    chk("rst_cause", cause, 0);
    chk("rst_result", result, 0);
    chk("rst_addr", mem.addr, 0);
    chk("rst_wstrb", mem.wstrb, 0);
    rst = 1;
    run_op(1, 0, 3'b010, 32'h1000, 32'd4, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_op(1, 0, 3'b000, 32'h2000, 32'd3, 32'h0, 32'h8011_2233, 0, 0);
    run_op(1, 0, 3'b100, 32'h2000, 32'd3, 32'h0, 32'h8011_2233, 1, 2);
    run_op(1, 0, 3'b101, 32'h2000, 32'd2, 32'h0, 32'h8011_2233, 0, 1);
    run_op(1, 0, 3'b001, 32'h2000, 32'd2, 32'h0, 32'h8011_2233, 0, 0);
    run_op(0, 1, 3'b001, 32'h3000, 32'd2, 32'h0000_ABCD, 32'h0, 0, 0);
    run_op(0, 1, 3'b000, 32'h3000, 32'd1, 32'h1234_56A5, 32'h0, 2, 0);
    run_op(0, 1, 3'b010, 32'h3000, 32'd0, 32'hCAFE_F00D, 32'h0, 0, 0);
    run_op(1, 0, 3'b010, 32'h4000, 32'd1, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'b011, 32'h4000, 32'd0, 32'h0, 32'h0, 0, 0);
    run_op(0, 1, 3'b100, 32'h4000, 32'd0, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'b001, 32'h4000, 32'd3, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'b010, 32'h5000, 32'd0, 32'h0, 32'h1111_2222, 3, -1);
    run_op(1, 0, 3'b010, 32'h5000, 32'd4, 32'h0, 32'h3333_4444, 0, TIMEOUT);
    run_op(1, 0, 3'b010, 32'h5000, 32'd8, 32'h0, 32'h5555_6666, 0, TIMEOUT + 1);
    run_op(1, 1, 3'b000, 32'h6000, 32'd1, 32'h0, 32'h0000_7F00, 0, 0);
    @(negedge clk);
    ctrl_ld = 1; ctrl_st = 0; funct3 = 3'b010; base = 32'h7000; ofs = 32'd8;
    @(negedge clk); mem.gnt = 1;
    @(negedge clk); mem.gnt = 0;
    @(negedge clk); rst = 0; ctrl_ld = 0;
    @(negedge clk); rst = 1;
    chk("mid_rst_req", mem.req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_addr", mem.addr, 0);
    mem.rvalid = 1; mem.rdata = 32'h1234_5678;
    @(negedge clk);
    mem.rvalid = 0;
    chk("late_rv_valid", ld_valid, 0);
    chk("late_rv_result", result, 0);
    chk("late_rv_stall", stall, 0);
    chk("late_rv_exc", exc, 0);
    last_res = '0;
    run_op(1, 0, 3'b010, 32'h1000, 32'd4, 32'h0, 32'h0BAD_F00D, 0, 0);
    for (int i = 0; i < 300; i++) begin
      bit l, s;
      logic [2:0] f3;
      int k, gd, rd;
      logic [2:0] legal [5];
      legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      k = $urandom_range(1, 3);
      l = k[0]; s = k[1];
      f3 = $urandom_range(0, 3) != 0 ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      gd = $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      rd = k == 0 ? -1 : k == 1 ? TIMEOUT : k == 2 ? TIMEOUT + 1 : $urandom_range(0, 3);
      run_op(l, s, f3, $urandom, 32'($urandom_range(0, 15)) - 32'd8, $urandom, $urandom, gd, rd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
